// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               err;
    logic               busy;
    logic [2:0]         grant_id;
    logic               uart_tx_write;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_finished;

    modport master (
        input  req, req_data, uart_tx_finished,
        output ack, err, busy, grant_id, uart_tx_write, uart_tx_data
    );

    modport slave (
        output req, req_data, uart_tx_finished,
        input  ack, err, busy, grant_id, uart_tx_write, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N_REQ byte sources
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_WIDTH       = 10
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          last_q, last_d;
    logic [2:0]          grant_q, grant_d;
    logic [7:0]          data_q, data_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    logic       hi_found, lo_found, found;
    logic [2:0] hi_pick, lo_pick, pick;
    logic [7:0] hi_data, lo_data, pick_data;

    // Two descending scans so the lowest index wins: first above last, then wrapping to 0..last.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        hi_data  = '0;
        lo_found = 1'b0;
        lo_pick  = '0;
        lo_data  = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (bus.req[j]) begin
                if (3'(j) > last_q) begin
                    hi_found = 1'b1;
                    hi_pick  = 3'(j);
                    hi_data  = bus.req_data[8*j +: 8];
                end else begin
                    lo_found = 1'b1;
                    lo_pick  = 3'(j);
                    lo_data  = bus.req_data[8*j +: 8];
                end
            end
        end
        found     = hi_found | lo_found;
        pick      = hi_found ? hi_pick : lo_pick;
        pick_data = hi_found ? hi_data : lo_data;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        write_d = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = START;
                    grant_d = pick;
                    data_d  = pick_data;
                    write_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = TO_WIDTH'(TIMEOUT_CYCLES);
            end
            WAIT: begin
                // A finish arriving on the same cycle as expiry still counts as success.
                if (bus.uart_tx_finished) begin
                    state_d = DONE;
                    ack_d   = N_REQ'(1) << grant_q;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    ack_d   = N_REQ'(1) << grant_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Registers follow the transmitter, which updates on the falling edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 3'(N_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack           = ack_q;
    assign bus.err           = err_q;
    assign bus.busy          = busy_q;
    assign bus.grant_id      = grant_q;
    assign bus.uart_tx_write = write_q;
    assign bus.uart_tx_data  = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 1023;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_WIDTH(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req_set;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_data;
        int          fin_delay;
        logic        exp_err;
        logic        drop;
        logic        mut;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Serve one frame: observe the grant, act as transmitter, check ack/err and latency.
    task automatic serve(input vec_t v);
        int   t;
        int   exp_t;
        logic ok;
        t = 0;
        while (bus.uart_tx_write !== 1'b1 && t < 64) begin
            @(posedge clk);
            t++;
        end
        chk("write_seen", 32'(t < 64), 32'd1);
        chk("grant_id", 32'(bus.grant_id), 32'(v.exp_id));
        chk("tx_data_latch", 32'(bus.uart_tx_data), 32'(v.exp_data));
        chk("busy_high", 32'(bus.busy), 32'd1);
        @(posedge clk);
        chk("write_one_cycle", 32'(bus.uart_tx_write), 32'd0);
        t  = 0;
        ok = 1'b1;
        while (bus.ack == '0 && t < 1100) begin
            bus.uart_tx_finished = (t == v.fin_delay);
            if (v.mut) bus.req_data = $urandom();
            if (bus.uart_tx_data !== v.exp_data || bus.uart_tx_write !== 1'b0 || bus.busy !== 1'b1)
                ok = 1'b0;
            @(posedge clk);
            t++;
        end
        bus.uart_tx_finished = 1'b0;
        // Finish sampled on the edge after it is driven, DONE visible one cycle later;
        // with no finish, DONE is entered TIMEOUT+1 cycles after WAIT.
        exp_t = (v.fin_delay < 0) ? TIMEOUT + 1 : v.fin_delay + 1;
        chk("ack_latency", 32'(t), 32'(exp_t));
        chk("frame_stable", 32'(ok), 32'd1);
        chk("ack_onehot", 32'(bus.ack), 32'd1 << v.exp_id);
        chk("err_flag", 32'(bus.err), 32'(v.exp_err));
        chk("data_in_done", 32'(bus.uart_tx_data), 32'(v.exp_data));
        if (v.drop) bus.req[v.exp_id] = 1'b0;
        @(posedge clk);
        chk("ack_one_cycle", 32'(bus.ack), 32'd0);
        chk("err_one_cycle", 32'(bus.err), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ack"}, 32'(bus.ack), 32'd0);
        chk({nm, "_err"}, 32'(bus.err), 32'd0);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_grant"}, 32'(bus.grant_id), 32'd0);
        chk({nm, "_write"}, 32'(bus.uart_tx_write), 32'd0);
        chk({nm, "_data"}, 32'(bus.uart_tx_data), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   t;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.uart_tx_finished = 1'b0;

        //         req_set  data          id  byte   delay  err   drop  mut
        vecs[0]  = '{4'b1111, 32'h13121110, 0, 8'h10, 20,   1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0000, 32'h13121110, 1, 8'h11, 20,   1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0000, 32'h13121110, 2, 8'h12, 20,   1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 32'h13121110, 3, 8'h13, 20,   1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0011, 32'h0000B1A0, 0, 8'hA0, 8,    1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 32'h0000B1A0, 1, 8'hB1, 8,    1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 32'h0000B1A0, 0, 8'hA0, 8,    1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 32'h0000B1A0, 1, 8'hB1, 8,    1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0001, 32'h00000041, 0, 8'h41, 320,  1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'b0100, 32'hD3C2B1A0, 2, 8'hC2, 10,   1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'b1001, 32'hD3C2B1A0, 3, 8'hD3, 10,   1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 32'hD3C2B1A0, 0, 8'hA0, 10,   1'b0, 1'b1, 1'b0};
        vecs[12] = '{4'b0010, 32'hD3C2B1A0, 1, 8'hB1, -1,   1'b1, 1'b1, 1'b0};
        vecs[13] = '{4'b0100, 32'hD3C2B1A0, 2, 8'hC2, 15,   1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'b1000, 32'hD3C2B1A0, 3, 8'hD3, 1023, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        chk_reset_outputs("reset_state");
        reset = 1'b0;
        @(posedge clk);

        // Finished pulse while idle must be ignored.
        bus.uart_tx_finished = 1'b1;
        @(posedge clk);
        bus.uart_tx_finished = 1'b0;
        repeat (3) @(posedge clk);
        chk("idle_fin_ack", 32'(bus.ack), 32'd0);
        chk("idle_fin_busy", 32'(bus.busy), 32'd0);
        chk("idle_fin_write", 32'(bus.uart_tx_write), 32'd0);

        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            bus.req_data = v.data;
            bus.req = bus.req | v.req_set;
            serve(v);
        end

        // Reset in the middle of WAIT abandons the frame without an ack.
        bus.req_data = 32'h00000055;
        bus.req = 4'b0001;
        t = 0;
        while (bus.uart_tx_write !== 1'b1 && t < 64) begin
            @(posedge clk);
            t++;
        end
        chk("rst_write_seen", 32'(t < 64), 32'd1);
        repeat (5) @(posedge clk);
        chk("rst_busy_before", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("async_reset");
        bus.req = '0;
        repeat (4) @(posedge clk);
        chk("reset_no_ack", 32'(bus.ack), 32'd0);
        reset = 1'b0;
        bus.req_data = 32'h13121110;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            serve(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
